// File: rtl/dump_pkg.sv
// -----------------------------------------------------------------------------
// dump_pkg
//
// Shared definitions for the memory dump engine and whatever top level muxes
// the data-memory bus between the CPU and the dump engine.
//
// Contents:
//   ENC_*     : raw 3-bit state encodings, usable by logic outside the engine
//   state_t   : dump engine FSM state type built on those encodings
//   nbytes()  : number of UART bytes needed to carry one data-memory word
// -----------------------------------------------------------------------------
package dump_pkg;

    localparam logic [2:0] ENC_IDLE = 3'd0;
    localparam logic [2:0] ENC_READ = 3'd1;
    localparam logic [2:0] ENC_SEND = 3'd2;
    localparam logic [2:0] ENC_WAIT = 3'd3;
    localparam logic [2:0] ENC_NEXT = 3'd4;
    localparam logic [2:0] ENC_FIN  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ENC_IDLE,
        S_READ = ENC_READ,
        S_SEND = ENC_SEND,
        S_WAIT = ENC_WAIT,
        S_NEXT = ENC_NEXT,
        S_FIN  = ENC_FIN
    } state_t;

    // Bytes per memory word, rounding a partial top byte up to a full byte.
    function automatic int nbytes(input int word_bits);
        return (word_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_dump_unit_if.sv
// -----------------------------------------------------------------------------
// mem_dump_unit_if
//
// Bundles the two buses the dump engine talks to: the combinational read port
// of the data memory and the byte handshake of the UART transmitter.
//
// Signals:
//   Mem_Rd    : read strobe to data memory
//   Mem_Addr  : read address to data memory
//   Mem_Data  : data-memory read output, valid combinationally while Mem_Rd=1
//   Tx_Data   : byte presented to the UART
//   Tx_Start  : one-cycle request to send Tx_Data
//   Tx_Done   : UART finished the current byte
//
// Modports:
//   master : the dump engine side
//   slave  : the memory/UART side
// -----------------------------------------------------------------------------
interface mem_dump_unit_if #(
    parameter int addr_bus  = 11,
    parameter int data_size = 16
);
    logic                 Mem_Rd;
    logic [addr_bus-1:0]  Mem_Addr;
    logic [data_size-1:0] Mem_Data;
    logic [7:0]           Tx_Data;
    logic                 Tx_Start;
    logic                 Tx_Done;

    modport master (
        output Mem_Rd, Mem_Addr, Tx_Data, Tx_Start,
        input  Mem_Data, Tx_Done
    );

    modport slave (
        input  Mem_Rd, Mem_Addr, Tx_Data, Tx_Start,
        output Mem_Data, Tx_Done
    );
endinterface

// File: rtl/mem_dump_unit.sv
// -----------------------------------------------------------------------------
// mem_dump_unit
//
// Read-only debug engine. On Start it walks Count words of data memory from
// Base_Addr (wrapping modulo 2**addr_bus), reads each word through the
// memory's combinational read port and streams it MSB byte first to the UART
// using a Tx_Start / Tx_Done byte handshake. Busy tells the top level to give
// the data-memory read port to this block. The block never writes memory.
//
// Ports:
//   Clk        : clock, rising edge
//   Reset      : asynchronous, active-high
//   Start      : begin a dump; only looked at while idle
//   Base_Addr  : first word address, captured when Start is accepted
//   Count      : number of words (0 .. 2**addr_bus), captured with Start
//   Busy       : dump in progress, memory read port owned by this block
//   Done       : one-cycle pulse at the end of a dump
//   bus        : memory read port + UART handshake (master side)
// -----------------------------------------------------------------------------
module mem_dump_unit
    import dump_pkg::*;
#(
    parameter int addr_bus  = 11,
    parameter int data_size = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [addr_bus-1:0] Base_Addr,
    input  logic [addr_bus:0]   Count,
    output logic                Busy,
    output logic                Done,
    mem_dump_unit_if.master     bus
);

    localparam int NB    = nbytes(data_size);
    localparam int SH_W  = NB * 8;
    localparam int IDX_W = $clog2(NB + 1);

    localparam logic [addr_bus-1:0] ADDR_ONE = addr_bus'(1);
    localparam logic [addr_bus:0]   CNT_ONE  = (addr_bus + 1)'(1);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);

    state_t               state;
    logic [addr_bus-1:0]  addr_q;      // current word address, doubles as Mem_Addr
    logic [addr_bus:0]    remaining;   // words still to be sent, incl. current one
    logic [SH_W-1:0]      shift_q;     // current word, next byte to send on top
    logic [IDX_W-1:0]     byte_idx;    // bytes of the current word already sent
    logic [7:0]           tx_data_q;
    logic                 tx_start_q;
    logic                 mem_rd_q;
    logic                 busy_q;
    logic                 done_q;

    logic [SH_W-1:0]      word_ext;
    logic [SH_W-1:0]      shifted;
    logic [IDX_W-1:0]     next_idx;
    logic [addr_bus:0]    remaining_dec;

    // NOTE: every signal here is assigned on every evaluation with no
    // conditional path, so the block stays purely combinational (no latch).
    always_comb begin
        word_ext      = SH_W'(bus.Mem_Data);   // zero-pads a partial top byte
        shifted       = shift_q << 8;
        next_idx      = byte_idx + IDX_ONE;
        remaining_dec = remaining - CNT_ONE;
    end

    // All outputs are registered: each one is set on the edge that enters the
    // state in which it must be active, so it is valid for that whole state.
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            remaining  <= '0;
            shift_q    <= '0;
            byte_idx   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to 0 unless re-asserted below.
            tx_start_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            done_q     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        busy_q <= 1'b1;
                        if (Count != '0) begin
                            addr_q    <= Base_Addr;
                            remaining <= Count;
                            mem_rd_q  <= 1'b1;
                            state     <= S_READ;
                        end else begin
                            // Empty dump: no memory access, no bytes.
                            done_q <= 1'b1;
                            state  <= S_FIN;
                        end
                    end
                end

                S_READ: begin
                    // Memory data is valid this cycle; the first byte is
                    // taken straight from it so SEND can start next cycle.
                    shift_q    <= word_ext;
                    byte_idx   <= '0;
                    tx_data_q  <= word_ext[SH_W-1 -: 8];
                    tx_start_q <= 1'b1;
                    state      <= S_SEND;
                end

                S_SEND: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    // Tx_Done only counts here; in any other state it is
                    // either stale (after reset) or spurious.
                    if (bus.Tx_Done) begin
                        shift_q  <= shifted;
                        byte_idx <= next_idx;
                        if (int'(next_idx) < NB) begin
                            tx_data_q  <= shifted[SH_W-1 -: 8];
                            tx_start_q <= 1'b1;
                            state      <= S_SEND;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    remaining <= remaining_dec;
                    if (remaining_dec == '0) begin
                        done_q <= 1'b1;
                        state  <= S_FIN;
                    end else begin
                        // Natural overflow of addr_q gives the wrap to 0.
                        addr_q   <= addr_q + ADDR_ONE;
                        mem_rd_q <= 1'b1;
                        state    <= S_READ;
                    end
                end

                S_FIN: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Mem_Rd   = mem_rd_q;
    assign bus.Mem_Addr = addr_q;
    assign bus.Tx_Data  = tx_data_q;
    assign bus.Tx_Start = tx_start_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_unit
//
// Two instances: a 16-bit-word engine and a 12-bit-word engine, both with an
// 11-bit address. Memory contents live in bench arrays driven onto Mem_Data.
// A simple UART responder returns Tx_Done a programmable number of cycles
// after each Tx_Start. A word-level model turns (base, count, memory) into the
// expected read addresses and byte stream; one negedge process compares every
// Mem_Rd, Tx_Start and Done against it. Directed tests add cycle-exact checks.
// -----------------------------------------------------------------------------
module tb_mem_dump_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start16 = 1'b0;
    logic        start12 = 1'b0;
    logic [10:0] base_addr = '0;
    logic [11:0] count = '0;
    logic        busy16, done16, busy12, done12;

    logic        uart_done16 = 1'b0;
    logic        uart_done12 = 1'b0;
    logic        inject_done = 1'b0;
    int          done_delay  = 3;

    logic [15:0] mem16 [2048];
    logic [11:0] mem12 [2048];

    logic [10:0] exp_addr16[$];
    logic [10:0] exp_addr12[$];
    logic [7:0]  exp_byte16[$];
    logic [7:0]  exp_byte12[$];
    int          exp_done16 = 0;
    int          exp_done12 = 0;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          start_cyc = 0;

    mem_dump_unit_if #(.addr_bus(11), .data_size(16)) bus16 ();
    mem_dump_unit_if #(.addr_bus(11), .data_size(12)) bus12 ();

    assign bus16.Mem_Data = mem16[bus16.Mem_Addr];
    assign bus16.Tx_Done  = uart_done16 | inject_done;
    assign bus12.Mem_Data = mem12[bus12.Mem_Addr];
    assign bus12.Tx_Done  = uart_done12;

    mem_dump_unit #(.addr_bus(11), .data_size(16)) dut16 (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start16),
        .Base_Addr (base_addr),
        .Count     (count),
        .Busy      (busy16),
        .Done      (done16),
        .bus       (bus16)
    );

    mem_dump_unit #(.addr_bus(11), .data_size(12)) dut12 (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start12),
        .Base_Addr (base_addr),
        .Count     (count),
        .Busy      (busy12),
        .Done      (done12),
        .bus       (bus12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level model: every word in the range is read once, in address
    // order modulo 2**11, and split into bytes most significant first.
    task automatic launch(input bit sel, input logic [10:0] base, input int words);
        logic [10:0] a;
        int unsigned w;
        int          nb;
        nb = sel ? (12 + 7) / 8 : (16 + 7) / 8;
        for (int i = 0; i < words; i++) begin
            a = base + 11'(i);
            w = sel ? 32'(mem12[a]) : 32'(mem16[a]);
            if (sel) exp_addr12.push_back(a);
            else     exp_addr16.push_back(a);
            for (int b = nb - 1; b >= 0; b--) begin
                if (sel) exp_byte12.push_back(8'(w >> (8 * b)));
                else     exp_byte16.push_back(8'(w >> (8 * b)));
            end
        end
        if (sel) exp_done12++;
        else     exp_done16++;
    endtask

    // UART responders: Tx_Done pulses for one cycle, done_delay cycles after
    // the cycle in which Tx_Start was high. A byte in flight always finishes.
    initial forever begin
        @(negedge clk);
        if (bus16.Tx_Start) begin
            repeat (done_delay) @(posedge clk);
            #1 uart_done16 = 1'b1;
            @(posedge clk);
            #1 uart_done16 = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus12.Tx_Start) begin
            @(posedge clk);
            #1 uart_done12 = 1'b1;
            @(posedge clk);
            #1 uart_done12 = 1'b0;
        end
    end

    // Compare process: every memory read, every byte request and every Done
    // must match the next item the model expects.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus16.Mem_Rd) begin
                check("rd16_expected", 32'(exp_addr16.size() != 0), 32'(1));
                if (exp_addr16.size() != 0)
                    check("rd16_addr", 32'(bus16.Mem_Addr), 32'(exp_addr16.pop_front()));
            end
            if (bus16.Tx_Start) begin
                check("tx16_expected", 32'(exp_byte16.size() != 0), 32'(1));
                if (exp_byte16.size() != 0)
                    check("tx16_byte", 32'(bus16.Tx_Data), 32'(exp_byte16.pop_front()));
            end
            if (done16) begin
                check("done16_expected", 32'(exp_done16 > 0), 32'(1));
                if (exp_done16 > 0) exp_done16--;
            end
            if (bus16.Mem_Rd || bus16.Tx_Start || done16)
                check("busy16_active", 32'(busy16), 32'(1));

            if (bus12.Mem_Rd) begin
                check("rd12_expected", 32'(exp_addr12.size() != 0), 32'(1));
                if (exp_addr12.size() != 0)
                    check("rd12_addr", 32'(bus12.Mem_Addr), 32'(exp_addr12.pop_front()));
            end
            if (bus12.Tx_Start) begin
                check("tx12_expected", 32'(exp_byte12.size() != 0), 32'(1));
                if (exp_byte12.size() != 0)
                    check("tx12_byte", 32'(bus12.Tx_Data), 32'(exp_byte12.pop_front()));
            end
            if (done12) begin
                check("done12_expected", 32'(exp_done12 > 0), 32'(1));
                if (exp_done12 > 0) exp_done12--;
            end
            if (bus12.Mem_Rd || bus12.Tx_Start || done12)
                check("busy12_active", 32'(busy12), 32'(1));
        end
    end

    // Start is sampled on the second rising edge below; cycle index 0 is the
    // cycle right after that edge.
    task automatic do_start(input bit sel, input logic [10:0] base, input logic [11:0] cnt);
        @(posedge clk);
        #1;
        base_addr = base;
        count     = cnt;
        if (sel) start12 = 1'b1;
        else     start16 = 1'b1;
        @(posedge clk);
        #1;
        start16   = 1'b0;
        start12   = 1'b0;
        base_addr = 11'h555;   // later changes must not matter
        count     = 12'd7;
        start_cyc = cyc;
    endtask

    task automatic wait_tx16(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus16.Tx_Start && k < budget);
        check("tx16_start_seen", 32'(bus16.Tx_Start), 32'(1));
    endtask

    // Waits for Done, checks its cycle index, Busy around it, and that the
    // model has nothing left over.
    task automatic finish_dump(input bit sel, input int exp_idx, input string name);
        int idx;
        idx = -1;
        for (int k = 0; k < exp_idx + 50; k++) begin
            @(negedge clk);
            if (sel ? done12 : done16) begin
                idx = cyc - start_cyc;
                break;
            end
        end
        check({name, "_done_cycle"}, 32'(idx), 32'(exp_idx));
        check({name, "_busy_at_done"}, 32'(sel ? busy12 : busy16), 32'(1));
        @(negedge clk);
        check({name, "_busy_after"}, 32'(sel ? busy12 : busy16), 32'(0));
        check({name, "_done_after"}, 32'(sel ? done12 : done16), 32'(0));
        if (sel)
            check({name, "_model_left"},
                  32'(exp_addr12.size() + exp_byte12.size() + exp_done12), 32'(0));
        else
            check({name, "_model_left"},
                  32'(exp_addr16.size() + exp_byte16.size() + exp_done16), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem16[i] = 16'((i * 37) ^ 16'h5A00);
            mem12[i] = 12'(i * 11);
        end
        mem16[11'h010] = 16'hABCD;
        mem16[11'h011] = 16'h1234;
        mem16[11'h7FF] = 16'h00FF;
        mem16[11'h000] = 16'h8001;
        mem12[11'h005] = 12'hFFF;

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset16_outputs", 32'({busy16, done16, bus16.Mem_Rd, bus16.Tx_Start,
                                      bus16.Mem_Addr, bus16.Tx_Data}), 32'(0));
        check("reset12_outputs", 32'({busy12, done12, bus12.Mem_Rd, bus12.Tx_Start,
                                      bus12.Mem_Addr, bus12.Tx_Data}), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: two words, Tx_Done 3 cycles after Tx_Start; 1+2*4+1 = 10 cycles
        // per word, so Done lands at cycle index 20.
        done_delay = 3;
        launch(1'b0, 11'h010, 2);
        check("t1_model_byte0", 32'(exp_byte16[0]), 32'h0000_00AB);
        check("t1_model_byte3", 32'(exp_byte16[3]), 32'h0000_0034);
        check("t1_model_addr1", 32'(exp_addr16[1]), 32'h0000_0011);
        do_start(1'b0, 11'h010, 12'd2);
        finish_dump(1'b0, 20, "t1");

        // T2: Count = 0 -> Done in cycle 0, no reads, no bytes.
        launch(1'b0, 11'h123, 0);
        do_start(1'b0, 11'h123, 12'd0);
        finish_dump(1'b0, 0, "t2");

        // T3: address wrap 0x7FF -> 0x000, Tx_Done after 1 cycle (6 per word).
        done_delay = 1;
        launch(1'b0, 11'h7FF, 2);
        check("t3_model_addr1", 32'(exp_addr16[1]), 32'h0000_0000);
        check("t3_model_byte2", 32'(exp_byte16[2]), 32'h0000_0080);
        do_start(1'b0, 11'h7FF, 12'd2);
        finish_dump(1'b0, 12, "t3");

        // T4: spurious Tx_Done during SEND and a Start while busy are ignored.
        done_delay = 3;
        launch(1'b0, 11'h010, 2);
        do_start(1'b0, 11'h010, 12'd2);
        wait_tx16(20);
        inject_done = 1'b1;
        @(posedge clk);
        #1;
        inject_done = 1'b0;
        start16     = 1'b1;
        base_addr   = 11'h7FF;
        count       = 12'd5;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        finish_dump(1'b0, 20, "t4");

        // T5: reset while waiting on the first byte; the in-flight Tx_Done
        // must cause nothing, then a new dump starts cleanly.
        launch(1'b0, 11'h010, 2);
        do_start(1'b0, 11'h010, 12'd2);
        wait_tx16(20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_reset_outputs", 32'({busy16, done16, bus16.Mem_Rd, bus16.Tx_Start,
                                       bus16.Mem_Addr, bus16.Tx_Data}), 32'(0));
        exp_addr16.delete();
        exp_byte16.delete();
        exp_done16 = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_quiet", 32'({busy16, bus16.Tx_Start, bus16.Mem_Rd, done16}), 32'(0));
        end
        launch(1'b0, 11'h011, 1);
        do_start(1'b0, 11'h011, 12'd1);
        finish_dump(1'b0, 10, "t5");

        // T6: 12-bit words, top byte zero-padded: 0xFFF -> 0F, FF.
        launch(1'b1, 11'h005, 1);
        check("t6_model_byte0", 32'(exp_byte12[0]), 32'h0000_000F);
        check("t6_model_byte1", 32'(exp_byte12[1]), 32'h0000_00FF);
        do_start(1'b1, 11'h005, 12'd1);
        finish_dump(1'b1, 6, "t6");

        // T7: Count = 2**11 from 0x400 covers every word once, wrapping.
        done_delay = 1;
        launch(1'b0, 11'h400, 2048);
        check("t7_model_wrap", 32'(exp_addr16[1024]), 32'h0000_0000);
        do_start(1'b0, 11'h400, 12'd2048);
        finish_dump(1'b0, 2048 * 6, "t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
